uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares the single uart_tx instance between N message sources (e.g. counter echo, "Fizz"/"Buzz" word generators, error reporter).
- Each source presents a short byte string plus length. The scheduler grants one source, latches its string, and streams it byte-by-byte into uart_tx using the tx_valid/tx_busy handshake.
- Sits between the FizzBuzz control logic and uart_tx in the top level.

---
 rtl/uart_tx_sched_if.sv | 21 ++
 rtl/uart_tx_sched.sv | 150 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Bundle of message-source and uart_tx-side signals for uart_tx_sched.
// The master side drives the requests and tx_busy. The slave side is the scheduler.
interface uart_tx_sched_if #(
  parameter int N_REQ   = 3,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
);
  logic [N_REQ-1:0]           req;
  logic [N_REQ*LEN_W-1:0]     req_len;
  logic [N_REQ*MAX_LEN*8-1:0] req_data;
  logic [N_REQ-1:0]           grant;
  logic [N_REQ-1:0]           done;
  logic [7:0]                 tx_data;
  logic                       tx_valid;
  logic                       tx_busy;

  modport master (output req, req_len, req_data, tx_busy,
                  input  grant, done, tx_data, tx_valid);
  modport slave  (input  req, req_len, req_data, tx_busy,
                  output grant, done, tx_data, tx_valid);
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that streams one source's byte string at a time into uart_tx.
// Optional macro UART_SCHED_CRLF_EN appends 0x0D 0x0A to every message.
module uart_tx_sched #(
  parameter int N_REQ   = 3,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_sched_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef UART_SCHED_CRLF_EN
  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_IDLE, CR, LF, DONE} state_t;
  localparam logic [1:0] PH_DATA = 2'd0, PH_CR = 2'd1, PH_LF = 2'd2;
  logic [1:0] phase_q;
`else
  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_IDLE, DONE} state_t;
`endif

  state_t                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [LEN_W-1:0]       idx_q, len_q;
  logic [MAX_LEN*8-1:0]   buf_q;
  logic [N_REQ-1:0]       grant_q, done_q;
  logic [7:0]             tx_data_q;
  logic                   tx_valid_q;

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;

  // Winner search: sources above the pointer first, then wrap to those at or below it.
  logic                 win_vld;
  logic [PTR_W-1:0]     win;
  logic [LEN_W-1:0]     win_len_raw, win_len;
  logic [MAX_LEN*8-1:0] win_data;
  always_comb begin
    win_vld     = 1'b0;
    win         = '0;
    win_len_raw = '0;
    win_data    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && bus.req[i] && (i > int'(ptr_q))) begin
        win_vld     = 1'b1;
        win         = PTR_W'(i);
        win_len_raw = bus.req_len[i*LEN_W +: LEN_W];
        win_data    = bus.req_data[i*MAX_LEN*8 +: MAX_LEN*8];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && bus.req[i] && (i <= int'(ptr_q))) begin
        win_vld     = 1'b1;
        win         = PTR_W'(i);
        win_len_raw = bus.req_len[i*LEN_W +: LEN_W];
        win_data    = bus.req_data[i*MAX_LEN*8 +: MAX_LEN*8];
      end
    end
    win_len = (win_len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : win_len_raw;
  end

  logic [7:0] cur_byte;
  always_comb begin
    cur_byte = 8'h00;
    for (int j = 0; j < MAX_LEN; j++)
      if (int'(idx_q) == j) cur_byte = buf_q[j*8 +: 8];
  end

  logic last_byte;
  assign last_byte = (idx_q + LEN_W'(1)) == len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_W'(N_REQ-1);
      idx_q      <= '0;
      len_q      <= '0;
      buf_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
`ifdef UART_SCHED_CRLF_EN
      phase_q    <= PH_DATA;
`endif
    end else begin
      tx_valid_q <= 1'b0;
      done_q     <= '0;
      case (state_q)
        IDLE: if (win_vld) begin
          grant_q <= N_REQ'(1) << win;
          ptr_q   <= win;
          idx_q   <= '0;
          len_q   <= win_len;
          buf_q   <= win_data;
`ifdef UART_SCHED_CRLF_EN
          phase_q <= PH_DATA;
          state_q <= (win_len == '0) ? CR : SEND;
`else
          state_q <= (win_len == '0) ? DONE : SEND;
`endif
        end
        SEND: if (!bus.tx_busy) begin
          tx_data_q  <= cur_byte;
          tx_valid_q <= 1'b1;
          state_q    <= WAIT_BUSY;
        end
        WAIT_BUSY: if (bus.tx_busy) state_q <= WAIT_IDLE;
        WAIT_IDLE: if (!bus.tx_busy) begin
`ifdef UART_SCHED_CRLF_EN
          case (phase_q)
            PH_DATA: begin
              idx_q   <= idx_q + LEN_W'(1);
              state_q <= last_byte ? CR : SEND;
            end
            PH_CR:   state_q <= LF;
            default: state_q <= DONE;
          endcase
`else
          idx_q   <= idx_q + LEN_W'(1);
          state_q <= last_byte ? DONE : SEND;
`endif
        end
`ifdef UART_SCHED_CRLF_EN
        CR: if (!bus.tx_busy) begin
          tx_data_q  <= 8'h0D;
          tx_valid_q <= 1'b1;
          phase_q    <= PH_CR;
          state_q    <= WAIT_BUSY;
        end
        LF: if (!bus.tx_busy) begin
          tx_data_q  <= 8'h0A;
          tx_valid_q <= 1'b1;
          phase_q    <= PH_LF;
          state_q    <= WAIT_BUSY;
        end
`endif
        // done takes over the grant bit, so the two never overlap.
        DONE: begin
          done_q  <= grant_q;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a simple uart_tx busy model.
module tb_uart_tx_sched;
  localparam int N_REQ = 3, MAX_LEN = 8, LEN_W = 4, FRAME = 10;
`ifdef UART_SCHED_CRLF_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.N_REQ(N_REQ), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus();
  uart_tx_sched #(.N_REQ(N_REQ), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int   cnt = 0;
  logic hold = 1'b0;
  always @(posedge clk)
    if (bus.tx_valid && cnt == 0) cnt <= FRAME;
    else if (cnt != 0) cnt <= cnt - 1;
  assign bus.tx_busy = (cnt != 0) || hold;

  logic [7:0]       txq[$];
  logic [N_REQ-1:0] gq[$];
  int               viol = 0;
  always @(negedge clk) begin
    if (bus.tx_valid) begin
      txq.push_back(bus.tx_data);
      gq.push_back(bus.grant);
      if (bus.tx_busy) viol++;
    end
    if ($countones(bus.grant) > 1 || $countones(bus.done) > 1) viol++;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_grant(output logic [N_REQ-1:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.grant != '0) begin g = bus.grant; break; end
    end
  endtask

  task automatic wait_done(output logic [N_REQ-1:0] d);
    d = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.done != '0) begin d = bus.done; break; end
    end
  endtask

  task automatic check_msg(input string nm, input int n, input logic [63:0] exp,
                           input logic [N_REQ-1:0] g);
    chk({nm, "_count"}, 64'(txq.size()), 64'(n + EXTRA));
    for (int j = 0; j < n; j++)
      if (j < txq.size()) chk($sformatf("%s_byte%0d", nm, j), 64'(txq[j]), 64'(exp[j*8 +: 8]));
`ifdef UART_SCHED_CRLF_EN
    if (n + 1 < txq.size()) begin
      chk({nm, "_cr"}, 64'(txq[n]),   64'h0D);
      chk({nm, "_lf"}, 64'(txq[n+1]), 64'h0A);
    end
`endif
    foreach (gq[k]) if (gq[k] != g) chk({nm, "_grant_at_strobe"}, 64'(gq[k]), 64'(g));
    txq.delete();
    gq.delete();
  endtask

  task automatic load(input int src, input logic [LEN_W-1:0] len, input logic [63:0] data);
    bus.req_len[src*LEN_W +: LEN_W] = len;
    bus.req_data[src*64 +: 64]      = data;
  endtask

  typedef struct {
    logic [N_REQ-1:0] req;
    int               src;
    logic [LEN_W-1:0] len;
    logic [63:0]      data;
    int               n_exp;
    logic [63:0]      exp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_REQ-1:0] g, d;
    logic [N_REQ-1:0] dseq[5];
    vecs[0] = '{3'b001, 0, 4'd2,  64'h0000_0000_0000_3731, 2, 64'h0000_0000_0000_3731};
    vecs[1] = '{3'b010, 1, 4'd0,  64'h0000_0000_0000_4444, 0, 64'h0};
    vecs[2] = '{3'b001, 0, 4'd12, 64'h4847_4645_4443_4241, 8, 64'h4847_4645_4443_4241};
    vecs[3] = '{3'b100, 2, 4'd3,  64'h0000_0000_007A_7978, 3, 64'h0000_0000_007A_7978};
    vecs[4] = '{3'b010, 1, 4'd8,  64'h3837_3635_3433_3231, 8, 64'h3837_3635_3433_3231};
    vecs[5] = '{3'b100, 2, 4'd1,  64'hFFFF_FFFF_FFFF_FF5A, 1, 64'h0000_0000_0000_005A};

    bus.req = '0; bus.req_len = '0; bus.req_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({bus.grant, bus.done, bus.tx_valid, bus.tx_data}), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // First-transaction latency: grant one cycle after req, strobe one after that.
    load(0, 4'd2, 64'h3731);
    bus.req = 3'b001;
    @(negedge clk);
    chk("lat_grant", 64'(bus.grant), 64'h1);
    bus.req = '0;
    @(negedge clk);
    chk("lat_valid", 64'({bus.tx_valid, bus.tx_data}), 64'h131);
    wait_done(d);
    chk("lat_done", 64'(d), 64'h1);
    check_msg("lat", 2, 64'h3731, 3'b001);

    for (int i = 0; i < 6; i++) begin
      bus.req_len = '0; bus.req_data = '0;
      load(vecs[i].src, vecs[i].len, vecs[i].data);
      bus.req = vecs[i].req;
      wait_grant(g);
      chk($sformatf("v%0d_grant", i), 64'(g), 64'(vecs[i].req));
      bus.req = '0;
      bus.req_len = '1;
      bus.req_data = ~bus.req_data;
      wait_done(d);
      chk($sformatf("v%0d_done", i), 64'(d), 64'(vecs[i].req));
      check_msg($sformatf("v%0d", i), vecs[i].n_exp, vecs[i].exp, vecs[i].req);
    end

    // All three held: pointer rests on source 2, so service order is 0,1,2,0,1.
    bus.req_len = '0; bus.req_data = '0;
    load(0, 4'd1, 64'h41); load(1, 4'd1, 64'h42); load(2, 4'd1, 64'h43);
    bus.req = 3'b111;
    for (int k = 0; k < 5; k++) begin
      wait_done(d);
      dseq[k] = d;
    end
    bus.req = '0;
    chk("rr_done0", 64'(dseq[0]), 64'h1);
    chk("rr_done1", 64'(dseq[1]), 64'h2);
    chk("rr_done2", 64'(dseq[2]), 64'h4);
    chk("rr_done3", 64'(dseq[3]), 64'h1);
    chk("rr_done4", 64'(dseq[4]), 64'h2);
    chk("rr_count", 64'(txq.size()), 64'(5 * (1 + EXTRA)));
    for (int k = 0; k < 5; k++)
      if (k * (1 + EXTRA) < txq.size())
        chk($sformatf("rr_byte%0d", k), 64'(txq[k*(1+EXTRA)]), 64'(8'h41 + 8'(k % 3)));
    txq.delete(); gq.delete();
    repeat (3) @(negedge clk);

    // uart_tx held busy externally: nothing may strobe until it is released.
    hold = 1'b1;
    bus.req_len = '0; bus.req_data = '0;
    load(0, 4'd4, 64'h7A7A_6946);
    bus.req = 3'b001;
    wait_grant(g);
    chk("hold_grant", 64'(g), 64'h1);
    bus.req = '0;
    repeat (50) @(negedge clk);
    chk("hold_no_strobe", 64'(txq.size()), 64'h0);
    hold = 1'b0;
    wait_done(d);
    chk("hold_done", 64'(d), 64'h1);
    check_msg("fizz", 4, 64'h7A7A_6946, 3'b001);

    // Reset in the middle of a 4-byte message, then a clean restart.
    load(0, 4'd4, 64'h5A59_5857);
    bus.req = 3'b001;
    wait_grant(g);
    bus.req = '0;
    for (int i = 0; i < 100 && txq.size() == 0; i++) @(negedge clk);
    chk("rst_first_byte", 64'(txq.size()), 64'h1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outputs", 64'({bus.grant, bus.done, bus.tx_valid, bus.tx_data}), 64'h0);
    repeat (2) @(negedge clk);
    chk("rst_held_outputs", 64'({bus.grant, bus.done, bus.tx_valid, bus.tx_data}), 64'h0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    txq.delete(); gq.delete();
    bus.req = 3'b001;
    wait_grant(g);
    chk("rst_restart_grant", 64'(g), 64'h1);
    bus.req = '0;
    wait_done(d);
    chk("rst_restart_done", 64'(d), 64'h1);
    check_msg("restart", 4, 64'h5A59_5857, 3'b001);

    chk("protocol_violations", 64'(viol), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
